// File: rtl/counter_ctrl_pkg.sv
// Shared constants for the counter control stage: FSM state encoding,
// count direction values and button indices.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Bit positions of the buttons in the packed press vector
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_HOLD  = 2;
  localparam int BTN_CLEAR = 3;
  localparam int NUM_BTN   = 4;

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchroniser, stable-level debounce counter and
// a single-cycle press pulse on each accepted 0->1 change.
module btn_debounce #(
  parameter int DB_CYCLES = 4,
  parameter int DB_W      = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync1_reg;
  logic            sync2_reg;
  logic            level_reg;
  logic            level_next;
  logic            level_d_reg;
  logic [DB_W-1:0] cnt_reg;
  logic [DB_W-1:0] cnt_next;

  // The level flips on the DB_CYCLES-th consecutive disagreeing sample
  always_comb begin
    cnt_next   = cnt_reg;
    level_next = level_reg;
    if (sync2_reg == level_reg) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_next   = '0;
      level_next = ~level_reg;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      level_reg   <= 1'b0;
      level_d_reg <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      sync1_reg   <= btn;
      sync2_reg   <= sync1_reg;
      level_reg   <= level_next;
      level_d_reg <= level_reg;
      cnt_reg     <= cnt_next;
    end
  end

  assign press = level_reg & ~level_d_reg;

endmodule

// File: rtl/counter_ctrl.sv
// Button-driven mode FSM for the 4-bit up/down counter. Optional bounce
// between 0 and max is enabled with `define COUNTER_CTRL_AUTOREV_EN.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int W         = 4,
  parameter int DB_CYCLES = 4,
  parameter int DB_W      = 3
) (
  input  logic         clk,
  input  logic         Clr,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_hold,
  input  logic         btn_clear,
  input  logic [W-1:0] data,
  output logic         enable,
  output logic         direction,
  output logic         ClrN,
  output logic [1:0]   mode
);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] press;

  assign btn_raw = {btn_clear, btn_hold, btn_down, btn_up};

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W)
      ) u_db (
        .clk   (clk),
        .rst   (Clr),
        .btn   (btn_raw[gi]),
        .press (press[gi])
      );
    end
  endgenerate

  state_t state_reg;
  state_t state_next;
  logic   enable_reg;
  logic   enable_next;
  logic   dir_reg;
  logic   dir_next;
  logic   clrn_reg;
  logic   clrn_next;

`ifdef COUNTER_CTRL_AUTOREV_EN
  // Turn one count early: the counter acts on our outputs one edge later
  localparam logic [W-1:0] TURN_HI = {{(W-1){1'b1}}, 1'b0};
  localparam logic [W-1:0] TURN_LO = W'(1);
`else
  logic data_unused;
  assign data_unused = ^data;
`endif

  always_comb begin
    state_next = state_reg;
    if (press[BTN_CLEAR]) begin
      state_next = IDLE;
    end else if (press[BTN_HOLD]) begin
      case (state_reg)
        UP, DOWN: state_next = HOLD;
        HOLD:     state_next = (dir_reg == DIR_DOWN) ? DOWN : UP;
        default:  state_next = state_reg;
      endcase
    end else if (press[BTN_DOWN]) begin
      state_next = DOWN;
    end else if (press[BTN_UP]) begin
      state_next = UP;
    end
`ifdef COUNTER_CTRL_AUTOREV_EN
    else if (state_reg == UP && enable_reg && data == TURN_HI) begin
      state_next = DOWN;
    end else if (state_reg == DOWN && enable_reg && data == TURN_LO) begin
      state_next = UP;
    end
`endif

    enable_next = (state_next == UP) || (state_next == DOWN);
    dir_next    = dir_reg;
    if (state_next == UP) begin
      dir_next = DIR_UP;
    end else if (state_next == DOWN) begin
      dir_next = DIR_DOWN;
    end
    clrn_next = ~press[BTN_CLEAR];
  end

  always_ff @(posedge clk or posedge Clr) begin
    if (Clr) begin
      state_reg  <= IDLE;
      enable_reg <= 1'b0;
      dir_reg    <= DIR_UP;
      clrn_reg   <= 1'b1;
    end else begin
      state_reg  <= state_next;
      enable_reg <= enable_next;
      dir_reg    <= dir_next;
      clrn_reg   <= clrn_next;
    end
  end

  assign enable    = enable_reg;
  assign direction = dir_reg;
  assign ClrN      = clrn_reg;
  assign mode      = state_reg;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed plus randomized bench for counter_ctrl with a behavioural
// reference model and a model of the downstream up/down counter.
module tb_counter_ctrl;

  localparam int W   = 4;
  localparam int DBC = 4;
  localparam int DBW = 3;

  localparam int S_IDLE = 0;
  localparam int S_UP   = 1;
  localparam int S_DOWN = 2;
  localparam int S_HOLD = 3;

  logic         clk = 1'b0;
  logic         Clr = 1'b1;
  logic         btn_up = 1'b0;
  logic         btn_down = 1'b0;
  logic         btn_hold = 1'b0;
  logic         btn_clear = 1'b0;
  logic [W-1:0] data = '0;
  logic         enable;
  logic         direction;
  logic         ClrN;
  logic [1:0]   mode;

  always #5 clk = ~clk;

  counter_ctrl #(.W(W), .DB_CYCLES(DBC), .DB_W(DBW)) dut (
    .clk       (clk),
    .Clr       (Clr),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_hold  (btn_hold),
    .btn_clear (btn_clear),
    .data      (data),
    .enable    (enable),
    .direction (direction),
    .ClrN      (ClrN),
    .mode      (mode)
  );

  int n_eval = 0;
  int n_fail = 0;
  int n_clrn_low = 0;

  // Reference model: raw history, per-button sample window, levels, events
  logic [3:0]   h1, h2;
  bit           win [4][DBC];
  bit           lvl [4];
  bit           ev  [4];
  int           m_state;
  bit           m_en, m_dir, m_clrn;
  logic [W-1:0] cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    h1 = '0; h2 = '0;
    for (int b = 0; b < 4; b++) begin
      lvl[b] = 1'b0; ev[b] = 1'b0;
      for (int i = 0; i < DBC; i++) win[b][i] = 1'b0;
    end
    m_state = S_IDLE; m_en = 1'b0; m_dir = 1'b0; m_clrn = 1'b1;
    cnt = '0;
  endtask

  // One rising edge; r holds the raw buttons seen at that edge
  task automatic model_edge(input logic [3:0] r);
    int  nxt;
    bit  all_diff;
    nxt = m_state;
    if (ev[3]) nxt = S_IDLE;
    else if (ev[2]) begin
      if (m_state == S_UP || m_state == S_DOWN) nxt = S_HOLD;
      else if (m_state == S_HOLD) nxt = m_dir ? S_DOWN : S_UP;
    end
    else if (ev[1]) nxt = S_DOWN;
    else if (ev[0]) nxt = S_UP;
`ifdef COUNTER_CTRL_AUTOREV_EN
    else if (m_state == S_UP && m_en && cnt == 4'hE) nxt = S_DOWN;
    else if (m_state == S_DOWN && m_en && cnt == 4'h1) nxt = S_UP;
`endif
    // downstream counter reacts to the outputs that were present at this edge
    if (!m_clrn) cnt = '0;
    else if (m_en) cnt = m_dir ? cnt - 1'b1 : cnt + 1'b1;
    m_clrn  = !ev[3];
    m_state = nxt;
    m_en    = (nxt == S_UP) || (nxt == S_DOWN);
    if (nxt == S_UP) m_dir = 1'b0;
    else if (nxt == S_DOWN) m_dir = 1'b1;
    // a level is accepted once the last DBC synchronised samples all disagree
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < DBC - 1; i++) win[b][i] = win[b][i+1];
      win[b][DBC-1] = h2[b];
      all_diff = 1'b1;
      for (int i = 0; i < DBC; i++) if (win[b][i] == lvl[b]) all_diff = 1'b0;
      ev[b] = 1'b0;
      if (all_diff) begin
        lvl[b] = ~lvl[b];
        ev[b]  = lvl[b];
      end
    end
    h2 = h1;
    h1 = r;
  endtask

  task automatic step();
    logic [3:0] r;
    @(posedge clk);
    r = {btn_clear, btn_hold, btn_down, btn_up};
    #1;
    model_edge(r);
    data = cnt;
    check("enable", 32'(enable), 32'(m_en));
    check("direction", 32'(direction), 32'(m_dir));
    check("ClrN", 32'(ClrN), 32'(m_clrn));
    check("mode", 32'(mode), 32'(m_state));
    if (ClrN === 1'b0) n_clrn_low++;
  endtask

  task automatic pulse(input logic [3:0] mask, input int hi, input int lo);
    n_clrn_low = 0;
    {btn_clear, btn_hold, btn_down, btn_up} = mask;
    repeat (hi) step();
    {btn_clear, btn_hold, btn_down, btn_up} = 4'b0000;
    repeat (lo) step();
    $display("pulse mask=%b hi=%0d lo=%0d -> mode=%0d en=%b dir=%b data=%h clrn_lows=%0d",
             mask, hi, lo, mode, enable, direction, data, n_clrn_low);
  endtask

  task automatic do_reset();
    Clr = 1'b1;
    #1;
    model_reset();
    data = cnt;
    check("rst_enable", 32'(enable), 32'd0);
    check("rst_direction", 32'(direction), 32'd0);
    check("rst_ClrN", 32'(ClrN), 32'd1);
    check("rst_mode", 32'(mode), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    Clr = 1'b0;
    $display("reset applied");
  endtask

  initial begin
    bit          turned;
    logic [3:0]  mask;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // clean up press: output after exactly 7 edges
    btn_up = 1'b1;
    repeat (6) step();
    check("up_before_7", 32'(enable), 32'd0);
    step();
    check("up_enable", 32'(enable), 32'd1);
    check("up_direction", 32'(direction), 32'd0);
    check("up_mode", 32'(mode), 32'd1);
    repeat (3) step();
    btn_up = 1'b0;
    repeat (8) step();
    $display("up press done mode=%0d", mode);

    pulse(4'b0010, 2, 8);
    check("glitch_mode", 32'(mode), 32'd1);

    pulse(4'b0100, 6, 6);
    check("hold_enable", 32'(enable), 32'd0);
    check("hold_mode", 32'(mode), 32'd3);
    pulse(4'b0100, 6, 6);
    check("resume_mode", 32'(mode), 32'd1);
    check("resume_direction", 32'(direction), 32'd0);

    pulse(4'b0010, 6, 6);
    check("down_mode", 32'(mode), 32'd2);
    pulse(4'b1000, 6, 6);
    check("clear_pulse_len", 32'(n_clrn_low), 32'd1);
    check("clear_enable", 32'(enable), 32'd0);
    check("clear_mode", 32'(mode), 32'd0);

    pulse(4'b0001, 6, 6);
    pulse(4'b1001, 6, 6);
    check("upclr_mode", 32'(mode), 32'd0);
    check("upclr_pulse_len", 32'(n_clrn_low), 32'd1);

    pulse(4'b0100, 6, 6);
    check("hold_in_idle_mode", 32'(mode), 32'd0);

`ifdef COUNTER_CTRL_AUTOREV_EN
    cnt = 4'hD;
    data = cnt;
    btn_up = 1'b1;
    turned = 1'b0;
    for (int i = 0; i < 30 && !turned; i++) begin
      step();
      if (direction === 1'b1) begin
        turned = 1'b1;
        check("autorev_turn_at_F", 32'(data), 32'hF);
      end
    end
    check("autorev_turned", 32'(turned), 32'd1);
    btn_up = 1'b0;
    step();
    check("autorev_after_F", 32'(data), 32'hE);
    for (int i = 0; i < 10; i++) begin
      step();
      check("autorev_no_wrap", 32'(data == '0), 32'd0);
    end
    $display("autorev bounce done data=%h dir=%b", data, direction);
`endif

    // reset while a button is held: fresh press after release of reset
    btn_up = 1'b1;
    repeat (8) step();
    do_reset();
    repeat (6) step();
    check("held_rst_pre", 32'(mode), 32'd0);
    step();
    check("held_rst_mode", 32'(mode), 32'd1);
    btn_up = 1'b0;
    repeat (6) step();

    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 3) != 0) mask = 4'b0001 << $urandom_range(0, 3);
      else mask = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 4) == 0) begin
        cnt = W'($urandom);
        data = cnt;
      end
      pulse(mask, $urandom_range(1, 10), $urandom_range(1, 10));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
